exe_stage_md: RTL and testbench

- Parametrised execute stage for the pipelined CPU.
- Carries the existing ALU datapath and adds four things:
  - a registered EX/MEM output,
  - an iterative multiply/divide unit with HI/LO registers,
  - mfhi/mflo forwarding into the result,
  - a stall handshake toward ID.
- Sits between the ID/EX register and the MEM stage. It replaces the combinational execute path.

---
 rtl/exe_stage_md_if.sv | 37 +++
 rtl/exe_stage_md.sv | 182 ++++++++++++++++++
 tb/tb_exe_stage_md.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_md_if.sv
// exe_stage_md_if: ID/EX inputs and EX/MEM outputs of the execute stage.
//   master : ID side / bench, drives the instruction slot and observes the results
//   slave  : execute stage (exe_stage_md)
//   Inputs : in_valid, jal, aluc[3:0], aluimm, shift, mdop[2:0], pc4, a, b, imm, rn
//   Outputs: stall (combinational), md_busy, out_valid, ealu, ern, eb (registered)
interface exe_stage_md_if #(
    parameter int WIDTH = 32,
    parameter int RN_W  = 5
);
    logic             in_valid;
    logic             jal;
    logic [3:0]       aluc;
    logic             aluimm;
    logic             shift;
    logic [2:0]       mdop;
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] imm;
    logic [RN_W-1:0]  rn;
    logic             stall;
    logic             md_busy;
    logic             out_valid;
    logic [WIDTH-1:0] ealu;
    logic [RN_W-1:0]  ern;
    logic [WIDTH-1:0] eb;

    modport master (
        output in_valid, jal, aluc, aluimm, shift, mdop, pc4, a, b, imm, rn,
        input  stall, md_busy, out_valid, ealu, ern, eb
    );

    modport slave (
        input  in_valid, jal, aluc, aluimm, shift, mdop, pc4, a, b, imm, rn,
        output stall, md_busy, out_valid, ealu, ern, eb
    );
endinterface

// File: rtl/exe_stage_md.sv
// exe_stage_md: execute stage with ALU, iterative multiply/divide (HI/LO),
// mfhi/mflo result forwarding, registered EX/MEM output and a stall toward ID.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : exe_stage_md_if.slave (instruction slot in, EX/MEM results out)
//
// ALU encoding (aluc): x000 add, x100 sub, x001 and, x101 or, x010 xor,
// x110 lui, 0011/1011 sll, 0111 srl, 1111 sra. Shifts shift B by A.
//
// mdop: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 none.
//
// state | meaning
// IDLE  | no mul/div in flight, may accept one
// MUL   | shift-add multiply iterating, md_busy high
// DIV   | restoring divide iterating, md_busy high
module exe_stage_md #(
    parameter int WIDTH = 32,
    parameter int RN_W  = 5
) (
    input logic           clk,
    input logic           rst,
    exe_stage_md_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             md_busy_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] ealu_q;
    logic [WIDTH-1:0] eb_q;
    logic [RN_W-1:0]  ern_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    // acc_hi:acc_lo is the product accumulator (MUL) or remainder:quotient (DIV)
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opd;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic [WIDTH-1:0]   alua, alub, alures, result;
    logic               md_any, md_start, is_sgn, stall;
    logic [WIDTH-1:0]   ma, mb;
    logic [WIDTH:0]     msum, dtrial;
    logic [WIDTH-1:0]   nx_hi, nx_lo;
    logic [2*WIDTH-1:0] prod, pfin;
    logic [WIDTH-1:0]   quo, rem;

    function automatic logic [WIDTH-1:0] alu(input logic [3:0] c,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        r = '0;
        case (c[2:0])
            3'b000: r = x + y;
            3'b100: r = x - y;
            3'b001: r = x & y;
            3'b101: r = x | y;
            3'b010: r = x ^ y;
            3'b110: r = {y[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            3'b011: r = y << x;
            3'b111: r = c[3] ? WIDTH'($signed(y) >>> x) : (y >> x);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign alua   = bus.shift  ? bus.imm : bus.a;
    assign alub   = bus.aluimm ? bus.imm : bus.b;
    assign alures = alu(bus.aluc, alua, alub);

    assign result = bus.jal           ? bus.pc4 + WIDTH'(4) :
                    (bus.mdop == 3'd5) ? hi :
                    (bus.mdop == 3'd6) ? lo : alures;

    assign md_any   = (bus.mdop >= 3'd1) && (bus.mdop <= 3'd6);
    assign md_start = (bus.mdop >= 3'd1) && (bus.mdop <= 3'd4);
    assign stall    = bus.in_valid && md_any && md_busy_q;

    // Both engines work on magnitudes; signs are reapplied when HI/LO are written.
    assign is_sgn = (bus.mdop == 3'd1) || (bus.mdop == 3'd3);
    assign ma     = (is_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mb     = (is_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    always_comb begin
        msum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
        dtrial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opd};
        nx_hi  = '0;
        nx_lo  = '0;
        if (state == MUL) begin
            nx_hi = msum[WIDTH:1];
            nx_lo = {msum[0], acc_lo[WIDTH-1:1]};
        end else if (!dtrial[WIDTH]) begin
            nx_hi = dtrial[WIDTH-1:0];
            nx_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            nx_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            nx_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
        prod = {nx_hi, nx_lo};
        pfin = neg_q ? -prod : prod;
        quo  = neg_q ? -nx_lo : nx_lo;
        rem  = neg_r ? -nx_hi : nx_hi;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            md_busy_q   <= 1'b0;
            out_valid_q <= 1'b0;
            ealu_q      <= '0;
            eb_q        <= '0;
            ern_q       <= '0;
            hi          <= '0;
            lo          <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opd         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
        end else begin
            if (!stall) begin
                out_valid_q <= bus.in_valid;
                ealu_q      <= result;
                ern_q       <= bus.rn;
                eb_q        <= bus.b;
            end else begin
                out_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.in_valid && !stall && md_start) begin
                        state     <= (bus.mdop <= 3'd2) ? MUL : DIV;
                        cnt       <= CW'(WIDTH);
                        md_busy_q <= 1'b1;
                        acc_hi    <= '0;
                        acc_lo    <= ma;
                        opd       <= mb;
                        neg_q     <= is_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r     <= is_sgn && bus.a[WIDTH-1];
                        dz        <= (bus.b == '0);
                    end
                end
                MUL, DIV: begin
                    acc_hi <= nx_hi;
                    acc_lo <= nx_lo;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= IDLE;
                        md_busy_q <= 1'b0;
                        if (state == MUL) begin
                            hi <= pfin[2*WIDTH-1:WIDTH];
                            lo <= pfin[WIDTH-1:0];
                        end else begin
                            // with a zero divisor the remainder already equals the dividend
                            hi <= rem;
                            lo <= dz ? '1 : quo;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    md_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall     = stall;
    assign bus.md_busy   = md_busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ealu      = ealu_q;
    assign bus.ern       = ern_q;
    assign bus.eb        = eb_q;
endmodule

// File: tb/tb_exe_stage_md.sv
module tb_exe_stage_md;
    localparam int W = 32;

    logic clk;
    logic rst;
    logic chk_on;
    int   n_pass;
    int   n_total;

    exe_stage_md_if #(.WIDTH(W), .RN_W(5)) bus ();

    exe_stage_md #(.WIDTH(W), .RN_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic        m_ov;
    logic [31:0] m_ealu, m_eb, m_hi, m_lo, p_hi, p_lo;
    logic [4:0]  m_ern;
    int          m_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] alu_m(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        case (c[2:0])
            3'd0: return x + y;
            3'd4: return x - y;
            3'd1: return x & y;
            3'd5: return x | y;
            3'd2: return x ^ y;
            3'd6: return y << 16;
            3'd3: return y << x;
            default: return c[3] ? 32'($signed(y) >>> x) : (y >> x);
        endcase
    endfunction

    // {hi, lo} of a mul/div, straight from arithmetic
    function automatic logic [63:0] md_m(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      ps;
        logic [63:0] pu;
        int          q, r;
        case (op)
            3'd1: begin ps = longint'($signed(x)) * longint'($signed(y)); return 64'(ps); end
            3'd2: begin pu = 64'(x) * 64'(y); return pu; end
            3'd3: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {32'(r), 32'(q)};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic logic exp_stall();
        return bus.in_valid && bus.mdop >= 3'd1 && bus.mdop <= 3'd6 && m_left > 0;
    endfunction

    // model: one step per edge, async reset
    initial begin
        logic [63:0] pr;
        logic [31:0] alub_m, alua_m;
        m_ov = 0; m_ealu = 0; m_eb = 0; m_ern = 0; m_hi = 0; m_lo = 0;
        p_hi = 0; p_lo = 0; m_left = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_ov = 0; m_ealu = 0; m_eb = 0; m_ern = 0; m_hi = 0; m_lo = 0; m_left = 0;
            end else begin
                if (!exp_stall()) begin
                    alua_m = bus.shift ? bus.imm : bus.a;
                    alub_m = bus.aluimm ? bus.imm : bus.b;
                    m_ov  = bus.in_valid;
                    m_ern = bus.rn;
                    m_eb  = bus.b;
                    if (bus.jal) m_ealu = bus.pc4 + 32'd4;
                    else if (bus.mdop == 3'd5) m_ealu = m_hi;
                    else if (bus.mdop == 3'd6) m_ealu = m_lo;
                    else m_ealu = alu_m(bus.aluc, alua_m, alub_m);
                end else begin
                    m_ov = 0;
                end
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
                end else if (bus.in_valid && bus.mdop >= 3'd1 && bus.mdop <= 3'd4) begin
                    pr = md_m(bus.mdop, bus.a, bus.b);
                    p_hi = pr[63:32];
                    p_lo = pr[31:0];
                    m_left = W;
                end
            end
        end
    end

    // compare process
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on && !rst) begin
                chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
                chk("ealu", bus.ealu, m_ealu);
                chk("ern", 32'(bus.ern), 32'(m_ern));
                chk("eb", bus.eb, m_eb);
                chk("md_busy", 32'(bus.md_busy), 32'(m_left > 0));
                chk("stall", 32'(bus.stall), 32'(exp_stall()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.jal = 0; bus.aluc = 0; bus.aluimm = 0; bus.shift = 0;
        bus.mdop = 0; bus.pc4 = 0; bus.a = 0; bus.b = 0; bus.imm = 0; bus.rn = 0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] c, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] r);
        idle();
        bus.in_valid = 1; bus.mdop = op; bus.aluc = c; bus.a = x; bus.b = y; bus.rn = r;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.md_busy && n < 200) begin tick(); n++; end
        chk("md_busy_timeout", 32'(bus.md_busy), 32'h0);
    endtask

    task automatic run_md(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ex_lo, input logic [31:0] ex_hi);
        issue(op, 4'd0, x, y, 5'd0);
        tick();
        idle();
        wait_idle();
        issue(3'd6, 4'd0, 0, 0, 5'd9);
        tick();
        chk("md_lo", bus.ealu, ex_lo);
        issue(3'd5, 4'd0, 0, 0, 5'd9);
        tick();
        chk("md_hi", bus.ealu, ex_hi);
    endtask

    task automatic pulse_rst();
        #2;
        rst = 1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_ealu", bus.ealu, 32'h0);
        chk("rst_ern", 32'(bus.ern), 32'h0);
        chk("rst_eb", bus.eb, 32'h0);
        chk("rst_md_busy", 32'(bus.md_busy), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        @(negedge clk);
        #1;
        rst = 0;
    endtask

    logic [31:0] sp [6];

    initial begin
        int n;
        n_pass = 0; n_total = 0; chk_on = 0;
        sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'hFFFFFFFF;
        sp[3] = 32'h80000000; sp[4] = 32'h7; sp[5] = 32'h2;
        rst = 1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_ealu", bus.ealu, 32'h0);
        chk("reset_md_busy", 32'(bus.md_busy), 32'h0);
        @(negedge clk);
        #1;
        rst = 0;
        chk_on = 1;

        // ALU add
        issue(3'd0, 4'd0, 32'd5, 32'd7, 5'd3);
        tick();
        chk("add_valid", 32'(bus.out_valid), 32'h1);
        chk("add_ealu", bus.ealu, 32'd12);
        chk("add_ern", 32'(bus.ern), 32'd3);
        chk("add_eb", bus.eb, 32'd7);

        // async reset mid-cycle
        pulse_rst();

        // jal
        issue(3'd0, 4'd0, 0, 0, 5'd31);
        bus.jal = 1; bus.pc4 = 32'h00400008;
        tick();
        chk("jal", bus.ealu, 32'h0040000C);
        bus.pc4 = 32'hFFFFFFFC;
        tick();
        chk("jal_wrap", bus.ealu, 32'h00000000);

        // mult then mfhi: stall for exactly W cycles
        issue(3'd1, 4'd0, 32'hFFFFFFFD, 32'd7, 5'd0);
        tick();
        issue(3'd5, 4'd0, 0, 0, 5'd8);
        #1;
        chk("mfhi_stall", 32'(bus.stall), 32'h1);
        n = 0;
        while (bus.stall && n < 100) begin
            tick();
            n++;
            chk("stall_bubble", 32'(bus.out_valid), 32'h0);
        end
        chk("stall_cycles", 32'(n), 32'd32);
        tick();
        chk("mfhi_valid", 32'(bus.out_valid), 32'h1);
        chk("mfhi_val", bus.ealu, 32'hFFFFFFFF);
        issue(3'd6, 4'd0, 0, 0, 5'd8);
        tick();
        chk("mflo_val", bus.ealu, 32'hFFFFFFEB);

        // divides and multu
        run_md(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run_md(3'd4, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd7);
        run_md(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
        run_md(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h1);

        // overlap: add runs during md_busy, second mult waits
        issue(3'd1, 4'd0, 32'd3, 32'd4, 5'd0);
        tick();
        issue(3'd0, 4'd0, 32'd1, 32'd2, 5'd4);
        #1;
        chk("add_no_stall", 32'(bus.stall), 32'h0);
        tick();
        chk("add_during_busy", bus.ealu, 32'd3);
        chk("add_busy_valid", 32'(bus.out_valid), 32'h1);
        issue(3'd1, 4'd0, 32'd5, 32'd6, 5'd0);
        #1;
        chk("mult2_stall", 32'(bus.stall), 32'h1);
        n = 0;
        while (bus.stall && n < 100) begin tick(); n++; end
        chk("mult2_wait_bound", 32'(n < 100), 32'h1);
        tick();
        chk("mult2_accepted", 32'(bus.md_busy), 32'h1);
        idle();
        wait_idle();

        // reset during DIV
        issue(3'd3, 4'd0, 32'd100, 32'd7, 5'd0);
        tick();
        idle();
        repeat (3) tick();
        pulse_rst();
        issue(3'd6, 4'd0, 0, 0, 5'd2);
        tick();
        chk("mflo_after_rst", bus.ealu, 32'h0);
        issue(3'd5, 4'd0, 0, 0, 5'd2);
        tick();
        chk("mfhi_after_rst", bus.ealu, 32'h0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            bus.in_valid = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 15);
            bus.mdop   = (r < 8) ? 3'd0 : 3'(r - 8);
            bus.jal    = ($urandom_range(0, 15) == 0);
            bus.aluc   = 4'($urandom);
            bus.aluimm = 1'($urandom);
            bus.shift  = 1'($urandom);
            bus.a      = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
            bus.b      = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
            bus.imm    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            bus.pc4    = $urandom;
            bus.rn     = 5'($urandom);
            tick();
        end
        idle();
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
